// File: rtl/seqgen_pkg.sv
// Shared types and widths for the serial pattern generator.
package seqgen_pkg;

  localparam int PATTERN_LEN_DEF = 8;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int LEN_W           = $clog2(PATTERN_LEN_DEF + 1);
  localparam int REP_W           = 4;

  // Gap counter holds GAP_CYCLES-1 down to 0, so it needs at least one bit.
  function automatic int gap_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int GAP_W = gap_width(GAP_CYCLES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered-history rising-edge detector; pulse is high while the input
// is 1 and its previous sample was 0.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // Previous-sample register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends the captured pattern MSB-first, repeated
// reps+1 times with idle gaps, then pulses done.
import seqgen_pkg::*;

module seq_pattern_gen #(
  parameter int   PATTERN_LEN = PATTERN_LEN_DEF,
  parameter int   GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter logic GAP_LEVEL   = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [PATTERN_LEN-1:0]           pattern,
  input  logic [$clog2(PATTERN_LEN+1)-1:0] len,
  input  logic [REP_W-1:0]                 reps,
  output logic                             w,
  output logic                             w_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int LW = $clog2(PATTERN_LEN + 1);
  localparam int GW = gap_width(GAP_CYCLES);

  state_e                 r_state, w_state_nxt;
  logic [PATTERN_LEN-1:0] r_shift, w_shift_nxt;
  logic [PATTERN_LEN-1:0] r_pat_cap, w_pat_cap_nxt;
  logic [LW-1:0]          r_len_cap, w_len_cap_nxt;
  logic [LW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [REP_W-1:0]       r_reps_left, w_reps_nxt;
  logic [GW-1:0]          r_gap_cnt, w_gap_nxt;
  logic                   r_w, w_w_nxt;
  logic                   r_w_valid, w_valid_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_rise;
  logic [LW-1:0]          w_len_clamp;
  logic [PATTERN_LEN-1:0] w_aligned;

  rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (start),
    .o_rise (w_rise)
  );

  // Left-align the pattern so the first bit to send sits at the MSB.
  assign w_len_clamp = (len > LW'(PATTERN_LEN)) ? LW'(PATTERN_LEN) : len;
  assign w_aligned   = pattern << (LW'(PATTERN_LEN) - w_len_clamp);

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= {PATTERN_LEN{1'b0}};
      r_pat_cap   <= {PATTERN_LEN{1'b0}};
      r_len_cap   <= {LW{1'b0}};
      r_bit_cnt   <= {LW{1'b0}};
      r_reps_left <= {REP_W{1'b0}};
      r_gap_cnt   <= {GW{1'b0}};
      r_w         <= GAP_LEVEL;
      r_w_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_pat_cap   <= w_pat_cap_nxt;
      r_len_cap   <= w_len_cap_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_reps_left <= w_reps_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_w         <= w_w_nxt;
      r_w_valid   <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; outputs default to the idle values
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_pat_cap_nxt = r_pat_cap;
    w_len_cap_nxt = r_len_cap;
    w_bit_cnt_nxt = r_bit_cnt;
    w_reps_nxt    = r_reps_left;
    w_gap_nxt     = r_gap_cnt;
    w_w_nxt       = GAP_LEVEL;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rise) begin
          w_pat_cap_nxt = w_aligned;
          w_len_cap_nxt = w_len_clamp;
          w_reps_nxt    = reps;
          if (w_len_clamp == {LW{1'b0}}) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = ST_SHIFT;
            w_shift_nxt   = w_aligned;
            w_bit_cnt_nxt = w_len_clamp - LW'(1'b1);
            w_w_nxt       = w_aligned[PATTERN_LEN-1];
            w_valid_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_bit_cnt != {LW{1'b0}}) begin
          w_shift_nxt   = r_shift << 1;
          w_bit_cnt_nxt = r_bit_cnt - LW'(1'b1);
          w_w_nxt       = w_shift_nxt[PATTERN_LEN-1];
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end else if (r_reps_left != {REP_W{1'b0}}) begin
          w_state_nxt = ST_GAP;
          w_reps_nxt  = r_reps_left - REP_W'(1'b1);
          w_gap_nxt   = GW'(GAP_CYCLES - 1);
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == {GW{1'b0}}) begin
          w_state_nxt   = ST_SHIFT;
          w_shift_nxt   = r_pat_cap;
          w_bit_cnt_nxt = r_len_cap - LW'(1'b1);
          w_w_nxt       = r_pat_cap[PATTERN_LEN-1];
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end else begin
          w_gap_nxt  = r_gap_cnt - GW'(1'b1);
          w_busy_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w       = r_w;
  assign w_valid = r_w_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed scenarios plus random bursts, each
// checked cycle by cycle against a frame-list model built from the pattern.
module tb_seq_pattern_gen;

  localparam int PL  = 8;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       w, w_valid, busy, done;

  int n_asserts = 0;
  int n_fail    = 0;

  seq_pattern_gen #(.PATTERN_LEN(PL), .GAP_CYCLES(GAP), .GAP_LEVEL(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .w       (w),
    .w_valid (w_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Compare {w, w_valid, busy, done} with the expected tuple.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {w, w_valid, busy, done};
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed(w,v,b,d)=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one burst and check every cycle. The expected output list comes
  // straight from the frame rules: bits MSB-first, gaps between frames,
  // one done cycle. Inputs are scrambled mid-burst and start stays high.
  task automatic run_burst(input string tag, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input int abort_at, input bit retoggle);
    logic [3:0] q[$];
    int eff;
    eff = (int'(l) > PL) ? PL : int'(l);
    for (int f = 0; f <= int'(r); f++) begin
      for (int i = eff - 1; i >= 0; i--) q.push_back({p[i], 1'b1, 1'b1, 1'b0});
      if (f < int'(r)) begin
        for (int g = 0; g < GAP; g++) q.push_back(4'b0010);
      end
    end
    q.push_back(4'b0001);
    pattern = p; len = l; reps = r; start = 1'b1;
    tick();
    for (int c = 0; c < q.size(); c++) begin
      chk(tag, q[c]);
      pattern = 8'($urandom); len = 4'($urandom); reps = 4'($urandom);
      if (retoggle && c == 1) start = 1'b0;
      if (retoggle && c == 3) start = 1'b1;
      if (c == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        break;
      end
      tick();
    end
    chk({tag, "_idle"}, 4'b0000);
    tick();
    chk({tag, "_nolaunch"}, 4'b0000);
    start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; len = 4'd0; reps = 4'd0;
    repeat (2) tick();
    chk("reset_state", 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_after_reset", 4'b0000);

    run_burst("t2_1111", 8'b0000_1111, 4'd4, 4'd0, -1, 1'b0);
    run_burst("t3_3frames", 8'b1011_0110, 4'd8, 4'd2, -1, 1'b0);
    run_burst("t4_retoggle", 8'b1100_1010, 4'd8, 4'd0, -1, 1'b1);
    run_burst("t4_relaunch", 8'b0101_0011, 4'd6, 4'd1, -1, 1'b0);
    run_burst("t5_len0", 8'hFF, 4'd0, 4'd0, -1, 1'b0);
    run_burst("t5_len12", 8'b1001_1101, 4'd12, 4'd0, -1, 1'b0);
    run_burst("t6_abort", 8'b1111_1111, 4'd8, 4'd0, 2, 1'b0);

    // abort and start edge together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; pattern = 8'hA5; len = 4'd8; reps = 4'd0;
    tick();
    abort = 1'b0;
    chk("t6_abort_start_idle", 4'b0000);
    tick();
    chk("t6_abort_start_held", 4'b0000);
    start = 1'b0;
    tick();

    // asynchronous reset in the middle of a frame
    pattern = 8'hFF; len = 4'd8; reps = 4'd1; start = 1'b1;
    repeat (3) tick();
    chk("t1_pre_reset_shift", 4'b1110);
    start = 1'b0;
    #2 reset = 1'b0;
    #1 chk("t1_reset_mid_shift", 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("t1_idle_after_reset", 4'b0000);

    for (int n = 0; n < 20; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_burst("rand", 8'($urandom), 4'($urandom_range(0, 12)),
                4'($urandom_range(0, 3)), ab, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
